// File: rtl/sensor_sim_pkg.sv
// Shared encodings and constants for the MT9P031 pixel-noise scheduler.
// LFSR polynomial x^8+x^6+x^5+x^4+1, seed 8'hAB.
package sensor_sim_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } sched_state_e;

    localparam logic [7:0] LFSR_SEED      = 8'hAB;
    localparam logic [7:0] LFSR_TAPS      = 8'hB8;
    localparam int         DATA_WIDTH_DEF = 8;

    // Fibonacci step: shift left, XOR of tapped bits enters at bit 0.
    function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sensor_noise_sched_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used to space and colour injected pixels.
// The seed is only reloaded by reset.
module noise_lfsr8
    import sensor_sim_pkg::*;
#(
    parameter logic [7:0] SEED = LFSR_SEED
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] ov_state
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr8_next(lfsr_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign ov_state = lfsr_q;

endmodule

// File: rtl/sensor_noise_sched.sv
// Frame-level noise-injection scheduler: on/off frame bursts, line ROI, LFSR spacing.
// Define SENSOR_NOISE_SCHED_HOT_PIXEL_EN to force injected pixels to all-ones.
module sensor_noise_sched
    import sensor_sim_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int FRAME_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_cfg_en,
    input  logic [7:0]             iv_gap_min,
    input  logic [15:0]            iv_roi_line_start,
    input  logic [15:0]            iv_roi_line_end,
    input  logic [FRAME_CNT_W-1:0] iv_frames_on,
    input  logic [FRAME_CNT_W-1:0] iv_frames_off,
    input  logic                   i_fval,
    input  logic                   i_lval,
    input  logic [DATA_WIDTH-1:0]  iv_pix_data,
    output logic                   o_fval,
    output logic                   o_lval,
    output logic [DATA_WIDTH-1:0]  ov_pix_data,
    output logic                   o_noise_frame,
    output logic [15:0]            ov_inject_cnt
);

    localparam logic [FRAME_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [FRAME_CNT_W-1:0] CNT_ONE = FRAME_CNT_W'(1);

    logic [7:0] lfsr;

    noise_lfsr8 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .ov_state(lfsr)
    );

    logic                   fval_q;
    logic                   lval_q;
    logic                   armed_q, armed_d;
    sched_state_e           state_q, state_d;
    logic [FRAME_CNT_W-1:0] on_cnt_q, on_cnt_d;
    logic [FRAME_CNT_W-1:0] off_cnt_q, off_cnt_d;

    logic                   en_q, en_d;
    logic [7:0]             gap_min_q, gap_min_d;
    logic [15:0]            roi_start_q, roi_start_d;
    logic [15:0]            roi_end_q, roi_end_d;
    logic [FRAME_CNT_W-1:0] frames_on_q, frames_on_d;
    logic [FRAME_CNT_W-1:0] frames_off_q, frames_off_d;

    logic [15:0]            line_q, line_d, line_eff;
    logic [7:0]             gap_q, gap_d, gap_eff;
    logic [15:0]            cnt_q, cnt_d, cnt_eff;
    logic [DATA_WIDTH-1:0]  pix_q, pix_d;
    logic                   nf_q, nf_d;

    logic                   fs, fe, lval_fall;
    logic                   roi_hit, inject;
    logic [DATA_WIDTH-1:0]  noise_val;

    assign fs        = i_fval & ~fval_q;
    assign fe        = ~i_fval & fval_q;
    assign lval_fall = i_fval & lval_q & ~i_lval;

    // The _d shadows double as the frame's effective configuration.
    always_comb begin
        en_d         = en_q;
        gap_min_d    = gap_min_q;
        roi_start_d  = roi_start_q;
        roi_end_d    = roi_end_q;
        frames_on_d  = frames_on_q;
        frames_off_d = frames_off_q;
        if (fs) begin
            en_d         = i_cfg_en;
            gap_min_d    = iv_gap_min;
            roi_start_d  = iv_roi_line_start;
            roi_end_d    = iv_roi_line_end;
            frames_on_d  = iv_frames_on;
            frames_off_d = iv_frames_off;
        end
    end

    always_comb begin
        state_d   = state_q;
        on_cnt_d  = on_cnt_q;
        off_cnt_d = off_cnt_q;
        if (fs) begin
            if (!en_d || frames_on_d == '0) begin
                state_d   = S_IDLE;
                on_cnt_d  = '0;
                off_cnt_d = '0;
            end else begin
                unique case (state_q)
                    S_ON: begin
                        if (on_cnt_q >= frames_on_d) begin
                            on_cnt_d = '0;
                            state_d  = (frames_off_d == '0) ? S_ON : S_OFF;
                        end
                    end
                    S_OFF: begin
                        if (off_cnt_q >= frames_off_d) begin
                            off_cnt_d = '0;
                            state_d   = S_ON;
                        end
                    end
                    default: state_d = S_ON;
                endcase
            end
        end else if (fe) begin
            if (state_q == S_ON && on_cnt_q != CNT_MAX) begin
                on_cnt_d = on_cnt_q + CNT_ONE;
            end
            if (state_q == S_OFF && off_cnt_q != CNT_MAX) begin
                off_cnt_d = off_cnt_q + CNT_ONE;
            end
        end
    end

    always_comb begin
`ifdef SENSOR_NOISE_SCHED_HOT_PIXEL_EN
        noise_val = '1;
`else
        noise_val = DATA_WIDTH'(lfsr) << (DATA_WIDTH - 8);
`endif
    end

    // A frame already running at reset release is not eligible (armed_q low).
    always_comb begin
        line_eff = fs ? 16'd0 : line_q;
        gap_eff  = fs ? 8'd0 : gap_q;
        cnt_eff  = fs ? 16'd0 : cnt_q;
        armed_d  = armed_q | ~i_fval;

        roi_hit = (line_eff >= roi_start_d) && (line_eff <= roi_end_d);
        inject  = armed_q && (state_d == S_ON) && i_fval && i_lval &&
                  roi_hit && (gap_eff >= gap_min_d) && lfsr[0];

        line_d = line_eff;
        if (lval_fall && line_eff != 16'hFFFF) begin
            line_d = line_eff + 16'd1;
        end

        gap_d = gap_eff;
        if (inject) begin
            gap_d = 8'd0;
        end else if (i_fval && i_lval && gap_eff != 8'hFF) begin
            gap_d = gap_eff + 8'd1;
        end

        cnt_d = cnt_eff;
        if (inject && cnt_eff != 16'hFFFF) begin
            cnt_d = cnt_eff + 16'd1;
        end

        pix_d = inject ? noise_val : iv_pix_data;
        nf_d  = armed_q && i_fval && (state_d == S_ON);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fval_q       <= 1'b0;
            lval_q       <= 1'b0;
            armed_q      <= 1'b0;
            state_q      <= S_IDLE;
            on_cnt_q     <= '0;
            off_cnt_q    <= '0;
            en_q         <= 1'b0;
            gap_min_q    <= '0;
            roi_start_q  <= '0;
            roi_end_q    <= '0;
            frames_on_q  <= '0;
            frames_off_q <= '0;
            line_q       <= '0;
            gap_q        <= '0;
            cnt_q        <= '0;
            pix_q        <= '0;
            nf_q         <= 1'b0;
        end else begin
            fval_q       <= i_fval;
            lval_q       <= i_lval;
            armed_q      <= armed_d;
            state_q      <= state_d;
            on_cnt_q     <= on_cnt_d;
            off_cnt_q    <= off_cnt_d;
            en_q         <= en_d;
            gap_min_q    <= gap_min_d;
            roi_start_q  <= roi_start_d;
            roi_end_q    <= roi_end_d;
            frames_on_q  <= frames_on_d;
            frames_off_q <= frames_off_d;
            line_q       <= line_d;
            gap_q        <= gap_d;
            cnt_q        <= cnt_d;
            pix_q        <= pix_d;
            nf_q         <= nf_d;
        end
    end

    assign o_fval        = fval_q;
    assign o_lval        = lval_q;
    assign ov_pix_data   = pix_q;
    assign o_noise_frame = nf_q;
    assign ov_inject_cnt = cnt_q;

endmodule

// File: tb/tb_sensor_noise_sched.sv
// Scoreboard bench for sensor_noise_sched against a frame-level reference model.
// Directed burst/ROI/gap/reset scenarios followed by randomized frames.
module tb_sensor_noise_sched;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_en = 1'b0;
    logic [7:0]    gap_min = 8'd0;
    logic [15:0]   roi_start = 16'd0;
    logic [15:0]   roi_end = 16'hFFFF;
    logic [7:0]    frames_on = 8'd0;
    logic [7:0]    frames_off = 8'd0;
    logic          i_fval = 1'b0;
    logic          i_lval = 1'b0;
    logic [DW-1:0] iv_pix_data = '0;
    logic          o_fval, o_lval, o_noise_frame;
    logic [DW-1:0] ov_pix_data;
    logic [15:0]   ov_inject_cnt;

    sensor_noise_sched dut (
        .clk              (clk),
        .reset            (reset),
        .i_cfg_en         (cfg_en),
        .iv_gap_min       (gap_min),
        .iv_roi_line_start(roi_start),
        .iv_roi_line_end  (roi_end),
        .iv_frames_on     (frames_on),
        .iv_frames_off    (frames_off),
        .i_fval           (i_fval),
        .i_lval           (i_lval),
        .iv_pix_data      (iv_pix_data),
        .o_fval           (o_fval),
        .o_lval           (o_lval),
        .ov_pix_data      (ov_pix_data),
        .o_noise_frame    (o_noise_frame),
        .ov_inject_cnt    (ov_inject_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          f;
        logic          l;
        logic [DW-1:0] d;
        logic          nf;
        logic [15:0]   cnt;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   obs_nf[$];
    int   obs_cnt[$];
    int   inj_pos[$];

    // Reference model state, kept per frame rather than per register.
    bit         m_pf, m_pl, m_armed, m_active, m_noisy;
    int         m_done, m_lines, m_since, m_cnt;
    logic [7:0] m_lfsr;
    int         s_en, s_gap, s_rs, s_re, s_on, s_off;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic model_reset();
        m_pf = 0; m_pl = 0; m_armed = 0; m_active = 0; m_noisy = 0;
        m_done = 0; m_lines = 0; m_since = 0; m_cnt = 0;
        m_lfsr = 8'hAB;
        s_en = 0; s_gap = 0; s_rs = 0; s_re = 0; s_on = 0; s_off = 0;
    endtask

    task automatic model(input bit f, input bit l, input logic [DW-1:0] d);
        bit   fs, fe, inj;
        exp_t e;
        fs = f && !m_pf;
        fe = !f && m_pf;
        if (fs) begin
            s_en = int'(cfg_en); s_gap = int'(gap_min);
            s_rs = int'(roi_start); s_re = int'(roi_end);
            s_on = int'(frames_on); s_off = int'(frames_off);
            m_lines = 0; m_since = 0; m_cnt = 0;
            if (s_en == 0 || s_on == 0) begin
                m_active = 0; m_noisy = 0; m_done = 0;
            end else if (!m_active) begin
                m_active = 1; m_noisy = 1; m_done = 0;
            end else if (m_noisy && m_done >= s_on) begin
                m_done = 0; m_noisy = (s_off == 0);
            end else if (!m_noisy && m_done >= s_off) begin
                m_done = 0; m_noisy = 1;
            end
        end
        if (fe && m_active) m_done++;
        inj = m_active && m_noisy && m_armed && f && l &&
              m_lines >= s_rs && m_lines <= s_re &&
              m_since >= s_gap && m_lfsr[0];
        e.f  = f;
        e.l  = l;
`ifdef SENSOR_NOISE_SCHED_HOT_PIXEL_EN
        e.d  = inj ? 8'hFF : d;
`else
        e.d  = inj ? m_lfsr : d;
`endif
        if (inj) begin
            m_since = 0;
            if (m_cnt < 65535) m_cnt++;
        end else if (f && l && m_since < 255) begin
            m_since++;
        end
        if (f && m_pl && !l) m_lines++;
        e.nf  = f && m_active && m_noisy && m_armed;
        e.cnt = 16'(m_cnt);
        expq.push_back(e);
        m_lfsr = lfsr_step(m_lfsr);
        m_pf = f;
        m_pl = l;
        if (!f) m_armed = 1;
    endtask

    task automatic step(input bit f, input bit l);
        logic [DW-1:0] d;
        d = DW'($urandom);
        @(negedge clk);
        reset = 1'b0;
        i_fval = f;
        i_lval = l;
        iv_pix_data = d;
        model(f, l, d);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = 1'b1;
            expq.push_back('0);
        end
        model_reset();
    endtask

    task automatic rand_cfg();
        cfg_en     = ($urandom_range(0, 7) != 0);
        gap_min    = 8'($urandom_range(0, 6));
        roi_start  = 16'($urandom_range(0, 3));
        roi_end    = 16'($urandom_range(0, 5));
        frames_on  = 8'($urandom_range(0, 3));
        frames_off = 8'($urandom_range(0, 2));
    endtask

    // evt: 1 = 3-clock reset, 2 = change frames_on/roi_start, 3 = random cfg
    task automatic frame(input int lines, input int px, input int evt_line, input int evt);
        step(1, 0);
        step(1, 0);
        for (int ln = 0; ln < lines; ln++) begin
            if (ln == evt_line) begin
                if (evt == 1) do_reset(3);
                else if (evt == 2) begin
                    frames_on = 8'd0;
                    roi_start = 16'd1000;
                end else rand_cfg();
            end
            for (int p = 0; p < px; p++) step(1, 1);
            step(1, 0);
            step(1, 0);
        end
        step(0, 0);
        step(0, 0);
        step(0, 0);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clear_obs();
        obs_nf.delete();
        obs_cnt.delete();
        inj_pos.delete();
    endtask

    // Monitor: scoreboard compare every clock, plus per-frame observations.
    initial begin
        exp_t        e;
        bit          was_f;
        bit          seen;
        logic [15:0] pc;
        int          pix;
        was_f = 0; seen = 0; pc = '0; pix = 0;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() != 0) begin
                e = expq.pop_front();
                checks++;
                if ({o_fval, o_lval, ov_pix_data, o_noise_frame, ov_inject_cnt} !== e) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t: got f%0b l%0b d%02h nf%0b cnt%0d expected f%0b l%0b d%02h nf%0b cnt%0d",
                             $time, o_fval, o_lval, ov_pix_data, o_noise_frame, ov_inject_cnt,
                             e.f, e.l, e.d, e.nf, e.cnt);
                end
            end
            if (o_fval && !was_f) begin
                pc = '0; pix = 0; seen = 0;
            end
            if (o_fval) begin
                if (o_noise_frame) seen = 1;
                if (ov_inject_cnt != pc) inj_pos.push_back(pix);
                pc = ov_inject_cnt;
                if (o_lval) pix++;
            end else if (was_f) begin
                obs_nf.push_back(int'(seen));
                obs_cnt.push_back(int'(pc));
            end
            was_f = o_fval;
        end
    end

    initial begin
        int min_sp;
        int bad;
        model_reset();
        do_reset(3);
        repeat (4) step(0, 0);

        // Burst pattern 2 on / 1 off over 5 frames
        cfg_en = 1'b1; frames_on = 8'd2; frames_off = 8'd1;
        gap_min = 8'd0; roi_start = 16'd0; roi_end = 16'hFFFF;
        clear_obs();
        repeat (5) frame(4, 16, -1, 0);
        chk("t1_frames", obs_nf.size(), 5);
        chk("t1_nf0", qget(obs_nf, 0), 1);
        chk("t1_nf1", qget(obs_nf, 1), 1);
        chk("t1_nf2", qget(obs_nf, 2), 0);
        chk("t1_nf3", qget(obs_nf, 3), 1);
        chk("t1_nf4", qget(obs_nf, 4), 1);
        chk("t1_clean_cnt", qget(obs_cnt, 2), 0);

        // ROI restricted to line 3
        frames_on = 8'd1; frames_off = 8'd0;
        roi_start = 16'd3; roi_end = 16'd3;
        clear_obs();
        frame(8, 64, -1, 0);
        bad = 0;
        foreach (inj_pos[i]) if (inj_pos[i] < 192 || inj_pos[i] > 255) bad++;
        chk("t2_outside_roi", bad, 0);
        chk("t2_has_inj", int'(inj_pos.size() > 0), 1);
        chk("t2_cnt_vs_pos", qget(obs_cnt, 0), inj_pos.size());

        // Minimum gap of 10 pixels
        gap_min = 8'd10; roi_start = 16'd0; roi_end = 16'd0;
        clear_obs();
        frame(1, 256, -1, 0);
        min_sp = 1000;
        for (int i = 1; i < inj_pos.size(); i++)
            if (inj_pos[i] - inj_pos[i-1] < min_sp) min_sp = inj_pos[i] - inj_pos[i-1];
        chk("t3_multi_inj", int'(inj_pos.size() >= 2), 1);
        chk("t3_min_spacing_ge11", int'(min_sp >= 11), 1);

        // Mid-frame config change applies from next frame
        gap_min = 8'd0; roi_start = 16'd0; roi_end = 16'hFFFF;
        frames_on = 8'd5; frames_off = 8'd0;
        clear_obs();
        frame(4, 16, 2, 2);
        frame(4, 16, -1, 0);
        frames_on = 8'd5; roi_start = 16'd0;
        frame(4, 16, -1, 0);
        chk("t4_a_nf", qget(obs_nf, 0), 1);
        chk("t4_a_inj", int'(qget(obs_cnt, 0) > 0), 1);
        chk("t4_b_nf", qget(obs_nf, 1), 0);
        chk("t4_b_cnt", qget(obs_cnt, 1), 0);
        chk("t4_c_nf", qget(obs_nf, 2), 1);

        // Reset at line 4 of a noisy frame
        frames_on = 8'd4; frames_off = 8'd1;
        clear_obs();
        frame(8, 16, 4, 1);
        frame(4, 16, -1, 0);
        chk("t5_fragments", obs_nf.size(), 3);
        chk("t5_pre_nf", qget(obs_nf, 0), 1);
        chk("t5_post_nf", qget(obs_nf, 1), 0);
        chk("t5_post_cnt", qget(obs_cnt, 1), 0);
        chk("t5_next_nf", qget(obs_nf, 2), 1);

        // Pass-through cases
        frames_on = 8'd0;
        clear_obs();
        frame(4, 16, -1, 0);
        frames_on = 8'd2; roi_start = 16'd2; roi_end = 16'd1;
        frame(4, 16, -1, 0);
        chk("t6_off_nf", qget(obs_nf, 0), 0);
        chk("t6_off_cnt", qget(obs_cnt, 0), 0);
        chk("t6_roi_nf", qget(obs_nf, 1), 1);
        chk("t6_roi_cnt", qget(obs_cnt, 1), 0);

        // Randomized frames, including one-clock frames and mid-frame changes
        for (int fr = 0; fr < 60; fr++) begin
            rand_cfg();
            if ($urandom_range(0, 5) == 0) begin
                step(1, 0);
                step(0, 0);
            end else begin
                frame($urandom_range(1, 5), $urandom_range(1, 20),
                      ($urandom_range(0, 3) == 0) ? 1 : -1, 3);
            end
            repeat ($urandom_range(0, 2)) step(0, 0);
        end

        step(0, 0);
        @(posedge clk);
        #3;
        chk("drain", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sensor_noise_sched.md
Name: sensor_noise_sched

Overview:
Frame-level scheduler and configurator for pixel-noise injection in the MT9P031 sensor model. It latches the noise configuration at each frame start and sequences noise-on and noise-off frame bursts. It restricts injection to a line window (ROI) and spaces injected pixels with an LFSR plus a minimum-gap counter. The block sits between the sensor pixel generator and the frame-buffer input, and adds one register stage to fval, lval and data.

Parameters:
DATA_WIDTH, 8, pixel width; legal range 8..16.
FRAME_CNT_W, 8, width of the on/off burst frame counters.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
i_cfg_en  in  1  master enable for noise injection
iv_gap_min  in  8  minimum number of pixels between two injections
iv_roi_line_start  in  16  first line eligible for injection (0-based, inclusive)
iv_roi_line_end  in  16  last line eligible for injection (inclusive)
iv_frames_on  in  FRAME_CNT_W  number of noisy frames per burst
iv_frames_off  in  FRAME_CNT_W  number of clean frames per burst
i_fval  in  1  frame valid
i_lval  in  1  line valid
iv_pix_data  in  DATA_WIDTH  pixel data
o_fval  out  1  frame valid, delayed 1 clock
o_lval  out  1  line valid, delayed 1 clock
ov_pix_data  out  DATA_WIDTH  pixel data or noise, delayed 1 clock
o_noise_frame  out  1  high for the whole frame when the current frame is a noisy frame
ov_inject_cnt  out  16  injections in the current frame; saturates at 16'hFFFF

Behaviour:
- Reset: all outputs 0, FSM = IDLE, LFSR = 8'hAB, all counters 0, shadow registers 0.
- Frame start (fs) = i_fval & ~fval_d. Frame end (fe) = ~i_fval & fval_d.
- Shadow registers capture all configuration inputs on fs only. Configuration changes mid-frame take effect at the next fs.
- Pipeline latency is exactly 1 clock for o_fval, o_lval, ov_pix_data and every input-to-output path.
- FSM states: IDLE, ON, OFF. Transitions are evaluated on fs, using the newly captured shadow values:
  - IDLE -> ON when cfg_en=1 and frames_on != 0. Otherwise stay in IDLE.
  - ON: on_cnt increments at each fe. When on_cnt reaches frames_on, go to OFF; if frames_off = 0, go back to ON instead (continuous noise). Clear on_cnt on exit.
  - OFF: off_cnt increments at each fe. When off_cnt reaches frames_off, go to ON and clear off_cnt.
  - Any state -> IDLE on fs when cfg_en=0 or frames_on=0; counters clear.
- o_noise_frame = (state == ON) between fs and fe, registered to align with o_fval.
- line_cnt: clears on fs; increments on the falling edge of i_lval while i_fval=1.
- roi_hit = start <= line_cnt <= end. If start > end, roi_hit is never true.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every clock. The seed is re-loaded only by reset.
- gap_cnt: clears on fs and on each injection. It increments on each clock with i_fval & i_lval and saturates at 8'hFF.
- inject = state==ON & i_fval & i_lval & roi_hit & (gap_cnt >= gap_min) & lfsr[0].
  - gap_min = 0 allows injection on any pixel where lfsr[0]=1.
  - Back-to-back injections are legal only when gap_min=0.
- Noise value = zero-extended {lfsr[7:0]} in the upper 8 bits of DATA_WIDTH, lower bits 0.
- ov_inject_cnt clears on fs and holds its final value after fe until the next fs.
- i_lval while i_fval=0: passed through to o_lval; no injection and no counting.
- Reset mid-frame: FSM returns to IDLE. No injection until a full fs is seen, because fval_d resets to 0. A frame already high at reset release counts as fs one clock later.
- fs and fe in adjacent clocks (one-clock frame): both are processed; the frame counts toward on_cnt/off_cnt.

Optional Feature:
SENSOR_NOISE_SCHED_HOT_PIXEL_EN
- Defined: injected pixels are forced to all-ones (hot pixel) instead of the LFSR value, and the LFSR value is still used only for spacing.
- Undefined: the LFSR-derived value is used as described above.

Decomposition:
- Package sensor_sim_pkg holds:
  - FSM state encoding: IDLE=2'd0, ON=2'd1, OFF=2'd2.
  - LFSR_SEED=8'hAB and LFSR tap mask.
  - DATA_WIDTH default.
- One sub-module, noise_lfsr8: free-running LFSR with seed parameter, clk/reset ports, and an 8-bit state output.

Test Plan:
1. cfg_en=1, frames_on=2, frames_off=1, 5 frames -> o_noise_frame pattern 1,1,0,1,1; no injection in frame 3.
2. ROI start=3, end=3, gap_min=0, noisy frame of 8 lines x 64 px -> injections appear only on output line 3, and ov_inject_cnt equals the count of lfsr[0]=1 pixels in that line.
3. gap_min=10, 1 line x 256 px -> every pair of injected pixels is at least 11 pixel positions apart.
4. Change iv_frames_on and iv_roi_line_start mid-frame -> current frame is unaffected; the new values apply from the next fs.
5. Assert reset for 3 clocks at line 4 of a noisy frame -> outputs read 0 during reset; no injection for the rest of that frame; the following frame is noisy again.
6. frames_on=0 or start > end -> ov_pix_data equals iv_pix_data delayed 1 clock for every pixel, and ov_inject_cnt = 0.
